aes128_iter_core: RTL and testbench

- Iterative AES-128 encryption core with a configurable number of state columns processed per cycle (1, 2 or 4).
- Uses valid/ready handshakes on both input and output.
- Runs an on-the-fly key schedule, one round key per round.
- Sits between the block-cipher mode wrapper and the bus interface.
- Supersedes the fixed 32-bit, ce/done-style core with a throughput/area trade-off and proper flow control.

---
 rtl/aes_pkg.sv | 78 +++++++
 rtl/aes_col_round.sv | 26 ++
 rtl/aes128_iter_core.sv | 140 ++++++++++++++
 tb/tb_aes128_iter_core.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 helpers: S-box, xtime, rcon, column helpers and core state encoding.
package aes_pkg;

    localparam int NR       = 10;
    localparam int NK_WORDS = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE, WAIT} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as a^254 by an addition chain, then the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] a3, a7, a15, a31, a63, a127, inv;
        a3   = gf_mul(gf_mul(a, a), a);
        a7   = gf_mul(gf_mul(a3, a3), a);
        a15  = gf_mul(gf_mul(a7, a7), a);
        a31  = gf_mul(gf_mul(a15, a15), a);
        a63  = gf_mul(gf_mul(a31, a31), a);
        a127 = gf_mul(gf_mul(a63, a63), a);
        inv  = gf_mul(a127, a127);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] col_get(input logic [127:0] s, input logic [1:0] c);
        return s[(3 - c) * 32 +: 32];
    endfunction

    function automatic logic [127:0] col_set(input logic [127:0] s, input logic [1:0] c,
                                             input logic [31:0] w);
        logic [127:0] t;
        t = s;
        t[(3 - c) * 32 +: 32] = w;
        return t;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] t;
        t = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned i = 0; i < 4; i++) begin
                t[(15 - (4 * c + i)) * 8 +: 8] = s[(15 - (4 * ((c + i) % 4) + i)) * 8 +: 8];
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/aes_col_round.sv
// One state column of an AES round: SubBytes, MixColumns (skipped on the last round), AddRoundKey.
module aes_col_round
    import aes_pkg::*;
(
    input  logic [31:0] col,
    input  logic [31:0] rk_word,
    input  logic        last,
    output logic [31:0] result
);

    logic [7:0] b0, b1, b2, b3;
    logic [31:0] mixed;

    always_comb begin
        b0 = sbox(col[31:24]);
        b1 = sbox(col[23:16]);
        b2 = sbox(col[15:8]);
        b3 = sbox(col[7:0]);
        mixed = {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
                 b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
                 b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
                 xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
        result = (last ? {b0, b1, b2, b3} : mixed) ^ rk_word;
    end

endmodule

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor, COLS state columns per cycle, valid/ready on both sides.
// Define AES_OUT_SKID_EN to add an output holding register so a new block can start while a result waits.
module aes128_iter_core
    import aes_pkg::*;
#(
    parameter int COLS = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ce,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    localparam int STEPS = 4 / COLS;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    state_t         state;
    logic [127:0]   st, rk, nxt, merged, sr, rkn;
    logic [3:0]     r;
    logic [SW-1:0]  s;
    logic [31:0]    t_word;
    logic           last_step, last_round;
    logic [31:0]    res [COLS];
    logic [1:0]     idx [COLS];

    assign in_ready   = ce & (state == IDLE);
    assign last_step  = (int'(s) == STEPS - 1);
    assign last_round = (r == 4'(NR));
    assign sr         = shift_rows(st);

    always_comb begin
        t_word = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])}
                 ^ {rcon(r), 24'h0};
        rkn[127:96] = rk[127:96] ^ t_word;
        rkn[95:64]  = rk[95:64]  ^ rkn[127:96];
        rkn[63:32]  = rk[63:32]  ^ rkn[95:64];
        rkn[31:0]   = rk[31:0]   ^ rkn[63:32];
    end

    for (genvar j = 0; j < COLS; j++) begin : g_col
        assign idx[j] = 2'(int'(s) * COLS + j);
        aes_col_round u_round (
            .col     (col_get(sr, idx[j])),
            .rk_word (col_get(rkn, idx[j])),
            .last    (last_round),
            .result  (res[j])
        );
    end

    // Columns finished in earlier steps of this round come from nxt; this step's columns overlay them.
    always_comb begin
        merged = nxt;
        for (int unsigned j = 0; j < COLS; j++) begin
            merged = col_set(merged, idx[j], res[j]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            st        <= '0;
            rk        <= '0;
            nxt       <= '0;
            r         <= '0;
            s         <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
            busy      <= 1'b0;
        end else if (ce) begin
`ifdef AES_OUT_SKID_EN
            if (out_valid && out_ready) out_valid <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st    <= data_in ^ key;
                        rk    <= key;
                        r     <= 4'd1;
                        s     <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (r == 4'd0 || r > 4'(NR)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        nxt <= merged;
                        if (last_step) begin
                            st <= merged;
                            rk <= rkn;
                            r  <= r + 4'd1;
                            s  <= '0;
                            if (last_round) begin
                                busy <= 1'b0;
`ifdef AES_OUT_SKID_EN
                                state <= WAIT;
`else
                                state <= DONE;
`endif
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
`ifdef AES_OUT_SKID_EN
                WAIT: begin
                    if (!out_valid || out_ready) begin
                        out_valid <= 1'b1;
                        data_out  <= st;
                        state     <= IDLE;
                    end
                end
`else
                // Output register loads one edge after the final round, giving 10*STEPS+1 latency.
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        data_out  <= st;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_iter_core.sv
// Scoreboard bench for aes128_iter_core at COLS = 1, 2 and 4 using FIPS-197 vectors.
module tb_aes128_iter_core;

`ifdef AES_OUT_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset;
    logic [127:0] data_in, key;
    logic         ce_v [3];
    logic         in_valid_v [3];
    logic         out_ready_v [3];
    logic         in_ready_v [3];
    logic         out_valid_v [3];
    logic         busy_v [3];
    logic [127:0] data_out_v [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes128_iter_core #(.COLS(g == 0 ? 1 : (g == 1 ? 2 : 4))) dut (
            .clock     (clock),
            .reset     (reset),
            .ce        (ce_v[g]),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .data_in   (data_in),
            .key       (key),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .data_out  (data_out_v[g]),
            .busy      (busy_v[g])
        );
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cur = 0;
    int t_acc = 0;
    logic [127:0] sb [$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Ciphertext monitor: every output handshake must match the oldest accepted block.
    always @(negedge clock) begin
        if (!reset && ce_v[cur] && out_valid_v[cur] && out_ready_v[cur]) begin
            check_eq("sb_nonempty", 128'(sb.size() > 0), 128'(1));
            if (sb.size() > 0) check_eq("ciphertext", data_out_v[cur], sb.pop_front());
        end
    end

    task automatic do_reset(input int u);
        @(posedge clock); #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_eq("rst_in_ready", 128'(in_ready_v[u]), 128'(1));
        check_eq("rst_out_valid", 128'(out_valid_v[u]), 128'(0));
        check_eq("rst_busy", 128'(busy_v[u]), 128'(0));
        check_eq("rst_data_out", data_out_v[u], '0);
    endtask

    task automatic set_or(input int u, input logic v);
        @(posedge clock); #1 out_ready_v[u] = v;
        @(negedge clock);
    endtask

    // Offers one block, scrambles data_in/key right after the accept edge.
    task automatic send(input int u, input logic [127:0] pt, input logic [127:0] k,
                        input logic [127:0] exp, input bit push);
        int n = 0;
        while (!in_ready_v[u] && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready_v[u]) begin
            check_eq("accept_timeout", 128'(in_ready_v[u]), 128'(1));
            return;
        end
        data_in = pt;
        key = k;
        in_valid_v[u] = 1'b1;
        @(posedge clock); #1;
        t_acc = cyc;
        if (push) sb.push_back(exp);
        in_valid_v[u] = 1'b0;
        data_in = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clock);
    endtask

    task automatic wait_ov(input int u, output int lat);
        int n = 0;
        while (!out_valid_v[u] && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (!out_valid_v[u]) check_eq("ov_timeout", 128'(out_valid_v[u]), 128'(1));
        lat = cyc - t_acc;
    endtask

    task automatic run_suite(input int u);
        int cols, steps, lat_exp, lat, a1;
        cols = (u == 0) ? 1 : ((u == 1) ? 2 : 4);
        steps = 4 / cols;
        lat_exp = 10 * steps + 1;
        do_reset(u);

        send(u, PT_C1, K_C1, CT_C1, 1'b1);
        check_eq("busy_run", 128'(busy_v[u]), 128'(1));
        wait_ov(u, lat);
        check_eq("lat_c1", 128'(lat), 128'(lat_exp));
        @(negedge clock);

        set_or(u, 1'b0);
        send(u, PT_B, K_B, CT_B, 1'b1);
        wait_ov(u, lat);
        check_eq("lat_b", 128'(lat), 128'(lat_exp));
        repeat (5) begin
            @(negedge clock);
            check_eq("hold_valid", 128'(out_valid_v[u]), 128'(1));
            check_eq("hold_data", data_out_v[u], CT_B);
            check_eq("hold_in_ready", 128'(in_ready_v[u]), 128'(SKID));
        end
        set_or(u, 1'b1);
        @(negedge clock);

        send(u, PT_C1, K_C1, CT_C1, 1'b1);
        repeat (3 * steps + steps / 2) @(posedge clock);
        #1 ce_v[u] = 1'b0;
        @(negedge clock);
        check_eq("ce0_in_ready", 128'(in_ready_v[u]), 128'(0));
        check_eq("ce0_busy", 128'(busy_v[u]), 128'(1));
        repeat (7) @(posedge clock);
        #1 ce_v[u] = 1'b1;
        @(negedge clock);
        wait_ov(u, lat);
        check_eq("lat_ce", 128'(lat), 128'(lat_exp + 7));
        @(negedge clock);

        send(u, PT_B, K_B, CT_B, 1'b0);
        repeat (5 * steps + steps / 2) @(posedge clock);
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_eq("abort_out_valid", 128'(out_valid_v[u]), 128'(0));
        check_eq("abort_busy", 128'(busy_v[u]), 128'(0));
        send(u, PT_C1, K_C1, CT_C1, 1'b1);
        wait_ov(u, lat);
        check_eq("lat_after_abort", 128'(lat), 128'(lat_exp));
        @(negedge clock);

        send(u, PT_B, K_B, CT_B, 1'b1);
        a1 = t_acc;
        wait_ov(u, lat);
        check_eq("lat_b2b_first", 128'(lat), 128'(lat_exp));
        send(u, PT_C1, K_C1, CT_C1, 1'b1);
        check_eq("b2b_gap", 128'(t_acc - a1), 128'(lat_exp + (SKID ? 1 : 2)));
        wait_ov(u, lat);
        check_eq("lat_b2b_second", 128'(lat), 128'(lat_exp));
        repeat (3) @(negedge clock);
        check_eq("sb_drained", 128'(sb.size()), '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        data_in = '0;
        key = '0;
        for (int i = 0; i < 3; i++) begin
            ce_v[i] = 1'b1;
            in_valid_v[i] = 1'b0;
            out_ready_v[i] = 1'b1;
        end
        for (int u = 0; u < 3; u++) begin
            cur = u;
            run_suite(u);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
